// File: rtl/switch_event_pkg.sv
// switch_event_pkg: shared state encoding and cycle-budget defaults for the switch path
package switch_event_pkg;
    localparam int unsigned C_LONG_LIMIT = 50000000;
    localparam int unsigned C_GAP_LIMIT  = 12500000;
    localparam int unsigned C_CNT_WIDTH  = 26;
    typedef enum logic [2:0] {IDLE, PRESSED, LONG_HELD, GAP, SECOND} state_e;
endpackage

// File: rtl/switch_edge_detect.sv
// switch_edge_detect: registers the debounced level twice and derives rise/fall
module switch_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic i_switch,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);
    logic r_sw_q, r_sw_dly_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sw_q     <= 1'b0;
            r_sw_dly_q <= 1'b0;
        end else begin
            r_sw_q     <= i_switch;
            r_sw_dly_q <= r_sw_q;
        end
    end
    assign o_level = r_sw_q;
    assign o_rise  = r_sw_q & ~r_sw_dly_q;
    assign o_fall  = ~r_sw_q & r_sw_dly_q;
endmodule

// File: rtl/switch_event_decoder.sv
// switch_event_decoder: turns a debounced switch level into press/release/short/long/double pulses
module switch_event_decoder
    import switch_event_pkg::*;
#(
    parameter int unsigned c_LONG_LIMIT = C_LONG_LIMIT,
    parameter int unsigned c_GAP_LIMIT  = C_GAP_LIMIT,
    parameter int unsigned c_CNT_WIDTH  = C_CNT_WIDTH
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_switch,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_short,
    output logic o_long,
    output logic o_double
);
    localparam logic [c_CNT_WIDTH-1:0] LONG_TERM = c_CNT_WIDTH'(c_LONG_LIMIT - 1);
    localparam logic [c_CNT_WIDTH-1:0] GAP_TERM  = c_CNT_WIDTH'(c_GAP_LIMIT - 1);
    logic rise, fall;
    state_e state_q, state_d;
    logic [c_CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic press_q, release_q, short_q, long_q, double_q;
    logic short_d, long_d, double_d;
    switch_edge_detect u_edge (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_switch (i_switch),
        .o_level  (o_level),
        .o_rise   (rise),
        .o_fall   (fall)
    );
    // An edge always takes priority over a terminal count arriving in the same cycle
    always_comb begin
        state_d  = state_q;
        short_d  = 1'b0;
        long_d   = 1'b0;
        double_d = 1'b0;
        case (state_q)
            IDLE:      if (rise) state_d = PRESSED;
            PRESSED:   if (fall) state_d = GAP;
                       else if (cnt_q == LONG_TERM) begin
                           long_d  = 1'b1;
                           state_d = LONG_HELD;
                       end
            LONG_HELD: if (fall) state_d = IDLE;
            GAP:       if (rise) begin
                           double_d = 1'b1;
                           state_d  = SECOND;
                       end else if (cnt_q == GAP_TERM) begin
                           short_d = 1'b1;
                           state_d = IDLE;
                       end
            SECOND:    if (fall) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
        cnt_d = (state_d != state_q) ? '0 :
                (state_q == PRESSED || state_q == GAP) ? cnt_q + c_CNT_WIDTH'(1) : cnt_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            short_q   <= 1'b0;
            long_q    <= 1'b0;
            double_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            press_q   <= rise;
            release_q <= fall;
            short_q   <= short_d;
            long_q    <= long_d;
            double_q  <= double_d;
        end
    end
    assign o_press   = press_q;
    assign o_release = release_q;
    assign o_short   = short_q;
    assign o_long    = long_q;
    assign o_double  = double_q;
endmodule

// File: doc/switch_event_decoder.md
# switch_event_decoder

Converts the clean, debounced level from the switch debounce filter into one-cycle event pulses: press, release, short click, long press and double click. It sits directly downstream of the debounce stage, and its outputs feed the control logic (mode select, counters, LEDs). All timing is expressed in clock cycles, so the thresholds can be retargeted by parameter.

## Interface
- c_LONG_LIMIT, 50000000: hold cycles before a long press fires (1 s at 50 MHz).
- c_GAP_LIMIT, 12500000: maximum cycles from release to the second press of a double click (250 ms at 50 MHz).
- c_CNT_WIDTH, 26: counter width; must satisfy 2^c_CNT_WIDTH > max(c_LONG_LIMIT, c_GAP_LIMIT).
- clk  input  1  system clock; the only clock.
- rst_n  input  1  asynchronous, active-low reset.
- i_switch  input  1  debounced switch level; 1 = pressed; already synchronous to clk.
- o_level  output  1  registered copy of i_switch.
- o_press  output  1  one-cycle pulse on every rising edge.
- o_release  output  1  one-cycle pulse on every falling edge.
- o_short  output  1  one-cycle pulse for a single click that got no second press within the gap.
- o_long  output  1  one-cycle pulse once the switch has been held for c_LONG_LIMIT cycles.
- o_double  output  1  one-cycle pulse on the second press of a double click.

## Operation
- Edge detection:
  - r_sw samples i_switch; r_sw_d samples r_sw.
  - rise = r_sw & ~r_sw_d; fall = ~r_sw & r_sw_d.
  - o_level = r_sw.
- One counter, cnt (c_CNT_WIDTH bits). It clears to 0 on every state change and otherwise increments by 1 while in PRESSED or GAP. It never wraps, because its terminal values are below 2^c_CNT_WIDTH.
- FSM states: IDLE, PRESSED, LONG_HELD, GAP, SECOND.
  - IDLE, rise: go to PRESSED.
  - PRESSED, fall: go to GAP.
  - PRESSED, cnt == c_LONG_LIMIT-1 with no fall: pulse o_long, go to LONG_HELD.
  - LONG_HELD, fall: go to IDLE. No o_short is produced.
  - GAP, rise: pulse o_double, go to SECOND.
  - GAP, cnt == c_GAP_LIMIT-1 with no rise: pulse o_short, go to IDLE.
  - SECOND, fall: go to IDLE. There is no long detection on the second press.
- o_press and o_release follow rise and fall in every state, independent of the FSM.
- Simultaneous events:
  - In PRESSED, if fall and the long terminal count occur in the same cycle, fall wins: go to GAP, no o_long.
  - In GAP, if rise and the gap terminal count occur in the same cycle, rise wins: o_double, no o_short.
- o_short, o_long and o_double are mutually exclusive per click sequence. At most one of them is asserted in any cycle.

## Timing
- All outputs are registered.
- Reset values: o_level = 0, all pulse outputs = 0, state = IDLE, cnt = 0, r_sw = r_sw_d = 0.
- Latency:
  - i_switch first sampled high at edge N gives r_sw = 1 after N.
  - o_press is high for exactly the cycle after edge N+1, with the same latency for o_release.
  - o_long is high c_LONG_LIMIT cycles after the cycle in which PRESSED was entered.
  - o_short is high c_GAP_LIMIT cycles after GAP was entered.
- Every pulse is exactly 1 cycle wide. Back-to-back pulses on the same output are impossible: the input needs at least 2 cycles per edge pair.
- Reset mid-operation: on deassertion the block is in IDLE with r_sw = 0.
  - If i_switch is held high through reset, one o_press fires 2 cycles after release of reset, and the FSM enters PRESSED normally.

## Structure
- Shared package switch_event_pkg holds:
  - the state enum (IDLE, PRESSED, LONG_HELD, GAP, SECOND);
  - the default constants for c_LONG_LIMIT, c_GAP_LIMIT and c_CNT_WIDTH, so the debounce filter and this block share one cycle-budget definition.
- One sub-module: switch_edge_detect, which contains the r_sw/r_sw_d registers and outputs level, rise and fall. The FSM and counter stay in the top module.

## Test plan
All scenarios use c_LONG_LIMIT = 20, c_GAP_LIMIT = 10 and run after reset release.
- Reset: hold rst_n = 0 with i_switch = 1, then release. Required: all outputs 0 during reset, and exactly one o_press 2 cycles after release.
- Short click: i_switch high 5 cycles, then low. Required: o_press, then o_release, then o_short exactly 10 cycles after GAP entry; no o_long or o_double.
- Long press: i_switch high 30 cycles. Required: o_long once, 20 cycles after PRESSED entry; o_release on the fall; no o_short.
- Double click: high 4, low 6, high 4, low. Required: o_press twice, o_double on the second press, and no o_short anywhere in the run.
- Boundaries:
  - Fall in the same cycle as the long terminal count: GAP is entered and o_long is never asserted.
  - Rise on the gap terminal cycle: o_double fires and o_short does not.
- Reset mid-hold: assert rst_n = 0 while in PRESSED at cnt = 15. Required: no o_long is ever produced and the FSM restarts from IDLE.
